// File: rtl/spi_regfile_rw.sv
// spi_regfile_rw: SPI mode-0 register-file peripheral with read-back.
// Frames are R/W bit, ADDR_W address bits, DATA_W data bits, MSB first.
// R/W = 1 writes the addressed register; R/W = 0 shifts it out on CIPO.
// All pins are asynchronous to clk and pass through SYNC-deep synchronisers.
module spi_regfile_rw #(
    parameter int                SYNC     = 2,
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 8,
    parameter int                NUM_REGS = 5,
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         nCS,
    input  logic                         SCLK,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int CMD_BITS   = 1 + ADDR_W;
    localparam int FRAME_BITS = CMD_BITS + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS) + 1;
    localparam int SHIFT_W    = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;

    localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0]  CMD_CNT    = CNT_W'(CMD_BITS);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Address lies inside the implemented register bank.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_W);
    endfunction

    logic [SYNC-1:0]     ncs_sync_r;
    logic [SYNC-1:0]     sclk_sync_r;
    logic [SYNC-1:0]     copi_sync_r;
    logic                ncs_dly_r;
    logic                sclk_dly_r;

    logic                ncs_fall_s;
    logic                ncs_rise_s;
    logic                sclk_rise_s;
    logic                sclk_fall_s;
    logic                copi_bit_s;

    state_t              state_r;
    state_t              next_state_s;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic [SHIFT_W-2:0]  shift_r;
    logic [SHIFT_W-1:0]  shift_nxt_s;
    logic                rw_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   tx_shift_r;
    logic [DATA_W-1:0]   rd_data_s;
    logic                cmd_done_s;
    logic                data_done_s;

    // Input synchronisers plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ncs_sync_r  <= {SYNC{1'b1}};
            sclk_sync_r <= {SYNC{1'b0}};
            copi_sync_r <= {SYNC{1'b0}};
            ncs_dly_r   <= 1'b1;
            sclk_dly_r  <= 1'b0;
        end else begin
            ncs_sync_r  <= {ncs_sync_r[SYNC-2:0], nCS};
            sclk_sync_r <= {sclk_sync_r[SYNC-2:0], SCLK};
            copi_sync_r <= {copi_sync_r[SYNC-2:0], COPI};
            ncs_dly_r   <= ncs_sync_r[SYNC-1];
            sclk_dly_r  <= sclk_sync_r[SYNC-1];
        end
    end

    assign ncs_fall_s  =  ncs_dly_r  & ~ncs_sync_r[SYNC-1];
    assign ncs_rise_s  = ~ncs_dly_r  &  ncs_sync_r[SYNC-1];
    assign sclk_rise_s = ~sclk_dly_r &  sclk_sync_r[SYNC-1];
    assign sclk_fall_s =  sclk_dly_r & ~sclk_sync_r[SYNC-1];
    assign copi_bit_s  =  copi_sync_r[SYNC-1];
    assign shift_nxt_s = {shift_r, copi_bit_s};

    // Read mux: addressed register, or zero for unimplemented addresses.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_REGS; k++) begin
            rd_data_s = (shift_nxt_s[ADDR_W-1:0] == ADDR_W'(k)) ?
                        regs_out[k*DATA_W +: DATA_W] : rd_data_s;
        end
    end

    // Next-state logic; a synced nCS rise always wins over an SCLK edge.
    always_comb begin
        next_state_s = state_r;
        cmd_done_s   = 1'b0;
        data_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ncs_fall_s) begin
                    next_state_s = ST_CMD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (ncs_rise_s) begin
                    next_state_s = ST_IDLE;
                end else if (sclk_rise_s && (bit_cnt_r == CMD_LAST)) begin
                    cmd_done_s   = 1'b1;
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_CMD;
                end
            end
            ST_DATA: begin
                if (ncs_rise_s) begin
                    next_state_s = ST_IDLE;
                end else if (sclk_rise_s && (bit_cnt_r == FRAME_LAST)) begin
                    data_done_s  = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_DONE: begin
                if (ncs_rise_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Frame datapath: shifting, register writes, CIPO and status strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_r  <= {CNT_W{1'b0}};
            shift_r    <= {(SHIFT_W-1){1'b0}};
            rw_r       <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            tx_shift_r <= {DATA_W{1'b0}};
            regs_out   <= {NUM_REGS{RST_VAL}};
            CIPO       <= 1'b0;
            cipo_oe    <= 1'b0;
            wr_pulse   <= 1'b0;
            wr_addr    <= {ADDR_W{1'b0}};
            frame_err  <= 1'b0;
        end else begin
            wr_pulse  <= 1'b0;
            frame_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ncs_fall_s) begin
                        bit_cnt_r <= {CNT_W{1'b0}};
                        shift_r   <= {(SHIFT_W-1){1'b0}};
                    end
                end
                ST_CMD: begin
                    if (ncs_rise_s) begin
                        frame_err <= 1'b1;
                        cipo_oe   <= 1'b0;
                        CIPO      <= 1'b0;
                    end else if (sclk_rise_s) begin
                        shift_r   <= shift_nxt_s[SHIFT_W-2:0];
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        if (cmd_done_s) begin
                            rw_r   <= shift_nxt_s[ADDR_W];
                            addr_r <= shift_nxt_s[ADDR_W-1:0];
                            if (!shift_nxt_s[ADDR_W]) begin
                                tx_shift_r <= rd_data_s;
                                CIPO       <= rd_data_s[DATA_W-1];
                                cipo_oe    <= 1'b1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (ncs_rise_s) begin
                        frame_err <= 1'b1;
                        cipo_oe   <= 1'b0;
                        CIPO      <= 1'b0;
                    end else if (sclk_rise_s) begin
                        shift_r   <= shift_nxt_s[SHIFT_W-2:0];
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        if (data_done_s) begin
                            CIPO <= 1'b0;
                            if (rw_r && addr_valid(addr_r)) begin
                                for (int k = 0; k < NUM_REGS; k++) begin
                                    if (addr_r == ADDR_W'(k)) begin
                                        regs_out[k*DATA_W +: DATA_W] <= shift_nxt_s[DATA_W-1:0];
                                    end
                                end
                                wr_pulse <= 1'b1;
                                wr_addr  <= addr_r;
                            end
                        end
                    end else if (sclk_fall_s && !rw_r && (bit_cnt_r > CMD_CNT)) begin
                        // The fall right after the last address bit must keep the
                        // MSB on CIPO; shifting starts only after the first data rise.
                        tx_shift_r <= tx_shift_r << 1;
                        CIPO       <= tx_shift_r[DATA_W-2];
                    end
                end
                ST_DONE: begin
                    if (ncs_rise_s) begin
                        cipo_oe <= 1'b0;
                        CIPO    <= 1'b0;
                    end
                end
                default: begin
                    cipo_oe <= 1'b0;
                    CIPO    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Self-checking bench for spi_regfile_rw: directed vector table, hand-written
// corner sequences and randomized frames against a frame-level reference model.
module tb_spi_regfile_rw;

    localparam int SYNC     = 2;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 5;
    localparam int HALF     = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nCS = 1'b1;
    logic        SCLK = 1'b0;
    logic        COPI = 1'b0;
    logic        CIPO;
    logic        cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] regs_out;
    logic        wr_pulse;
    logic [ADDR_W-1:0] wr_addr;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int err_cnt = 0;

    logic [7:0] mregs [NUM_REGS];
    logic [6:0] m_wr_addr;

    typedef struct {
        logic [23:0] mosi;
        int          nbits;
        logic [23:0] exp_miso;
        logic [23:0] exp_oe;
        int          exp_wr;
        int          exp_err;
        logic [39:0] exp_regs;
        logic [6:0]  exp_wr_addr;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    spi_regfile_rw #(
        .SYNC     (SYNC),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .RST_VAL  (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nCS       (nCS),
        .SCLK      (SCLK),
        .COPI      (COPI),
        .CIPO      (CIPO),
        .cipo_oe   (cipo_oe),
        .regs_out  (regs_out),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    // Count strobe-high cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_pulse === 1'b1) wr_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] pack_model();
        logic [39:0] p;
        p = 40'h0;
        for (int k = 0; k < NUM_REGS; k++) p[k*8 +: 8] = mregs[k];
        return p;
    endfunction

    // Frame-level model: decode the bit stream, predict CIPO/oe per bit and update regs.
    task automatic model_frame(input logic [23:0] mosi, input int nbits,
                               output logic [23:0] miso, output logic [23:0] oe,
                               output int nwr, output int nerr);
        logic rw;
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] rdval;
        logic b;
        int ai;
        rw = 1'b0; addr = 7'h0; data = 8'h0; miso = 24'h0; oe = 24'h0;
        for (int i = 0; i < nbits; i++) begin
            b = mosi[nbits-1-i];
            if (i == 0) rw = b;
            else if (i < 8) addr = {addr[5:0], b};
            else if (i < 16) data = {data[6:0], b};
        end
        ai = int'(addr);
        rdval = (ai < NUM_REGS) ? mregs[ai] : 8'h00;
        for (int i = 0; i < nbits; i++) begin
            miso = {miso[22:0], (!rw && i >= 8 && i < 16) ? rdval[15-i] : 1'b0};
            oe   = {oe[22:0], (!rw && i >= 8)};
        end
        nerr = (nbits < 16) ? 1 : 0;
        nwr = 0;
        if (nbits >= 16 && rw && ai < NUM_REGS) begin
            mregs[ai] = data;
            m_wr_addr = addr;
            nwr = 1;
        end
    endtask

    // Drive one SPI mode-0 frame of nbits; collide raises nCS with the last SCLK rise.
    task automatic spi_xfer(input logic [23:0] mosi, input int nbits, input bit collide,
                            output logic [23:0] miso, output logic [23:0] oe);
        miso = 24'h0;
        oe = 24'h0;
        nCS = 1'b0;
        wait_clks(HALF);
        for (int i = nbits - 1; i >= 0; i--) begin
            COPI = mosi[i];
            wait_clks(HALF);
            miso = {miso[22:0], CIPO};
            oe   = {oe[22:0], cipo_oe};
            if (collide && i == 0) begin
                SCLK = 1'b1;
                nCS = 1'b1;
            end else begin
                SCLK = 1'b1;
            end
            wait_clks(HALF);
            SCLK = 1'b0;
        end
        if (!collide) begin
            wait_clks(HALF);
            nCS = 1'b1;
        end
        COPI = 1'b0;
        wait_clks(10);
    endtask

    // Apply a frame and compare everything against the reference model.
    task automatic run_model_frame(input string tag, input logic [23:0] mosi, input int nbits);
        logic [23:0] miso, oe, em, eo;
        int w0, e0, ew, ee;
        w0 = wr_cnt; e0 = err_cnt;
        model_frame(mosi, nbits, em, eo, ew, ee);
        spi_xfer(mosi, nbits, 1'b0, miso, oe);
        check({tag, " miso"}, 64'(miso), 64'(em));
        check({tag, " oe"}, 64'(oe), 64'(eo));
        check({tag, " wr_pulse"}, 64'(wr_cnt - w0), 64'(ew));
        check({tag, " frame_err"}, 64'(err_cnt - e0), 64'(ee));
        check({tag, " regs"}, 64'(regs_out), 64'(pack_model()));
        check({tag, " wr_addr"}, 64'(wr_addr), 64'(m_wr_addr));
        check({tag, " idle"}, {62'h0, cipo_oe, CIPO}, 64'h0);
    endtask

    initial begin
        logic [23:0] miso, oe, full;
        int w0, e0, nb, sel;

        vecs[0] = '{24'h0082A5, 16, 24'h000000, 24'h000000, 1, 0, 40'h0000A50000, 7'h02};
        vecs[1] = '{24'h000200, 16, 24'h0000A5, 24'h0000FF, 0, 0, 40'h0000A50000, 7'h02};
        vecs[2] = '{24'h009077, 16, 24'h000000, 24'h000000, 0, 0, 40'h0000A50000, 7'h02};
        vecs[3] = '{24'h001000, 16, 24'h000000, 24'h0000FF, 0, 0, 40'h0000A50000, 7'h02};
        vecs[4] = '{24'h000207, 10, 24'h000000, 24'h000000, 0, 1, 40'h0000A50000, 7'h02};
        vecs[5] = '{24'h00815A, 16, 24'h000000, 24'h000000, 1, 0, 40'h0000A55A00, 7'h01};
        vecs[6] = '{24'h843CFF, 24, 24'h000000, 24'h000000, 1, 0, 40'h3C00A55A00, 7'h04};
        vecs[7] = '{24'h040000, 24, 24'h003C00, 24'h00FFFF, 0, 0, 40'h3C00A55A00, 7'h04};
        vecs[8] = '{24'h000020, 12, 24'h00000A, 24'h00000F, 0, 1, 40'h3C00A55A00, 7'h04};

        // Reset state
        rst_n = 1'b0;
        wait_clks(3);
        check("reset regs", 64'(regs_out), 64'h0);
        check("reset outs", {59'h0, CIPO, cipo_oe, wr_pulse, frame_err, 1'b0}, 64'h0);
        check("reset wr_addr", 64'(wr_addr), 64'h0);
        rst_n = 1'b1;
        wait_clks(5);

        // Directed vector table
        for (int v = 0; v < 9; v++) begin
            w0 = wr_cnt; e0 = err_cnt;
            spi_xfer(vecs[v].mosi, vecs[v].nbits, 1'b0, miso, oe);
            check($sformatf("vec%0d miso", v), 64'(miso), 64'(vecs[v].exp_miso));
            check($sformatf("vec%0d oe", v), 64'(oe), 64'(vecs[v].exp_oe));
            check($sformatf("vec%0d wr_pulse", v), 64'(wr_cnt - w0), 64'(vecs[v].exp_wr));
            check($sformatf("vec%0d frame_err", v), 64'(err_cnt - e0), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d regs", v), 64'(regs_out), 64'(vecs[v].exp_regs));
            check($sformatf("vec%0d wr_addr", v), 64'(wr_addr), 64'(vecs[v].exp_wr_addr));
            check($sformatf("vec%0d idle", v), {62'h0, cipo_oe, CIPO}, 64'h0);
        end

        // Reset in the middle of a write after 12 bits
        full = 24'h008311;
        nCS = 1'b0;
        wait_clks(HALF);
        for (int i = 15; i >= 4; i--) begin
            COPI = full[i];
            wait_clks(HALF);
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
        end
        w0 = wr_cnt; e0 = err_cnt;
        rst_n = 1'b0;
        wait_clks(2);
        nCS = 1'b1;
        COPI = 1'b0;
        check("midrst regs", 64'(regs_out), 64'h0);
        check("midrst outs", {60'h0, CIPO, cipo_oe, wr_pulse, frame_err}, 64'h0);
        check("midrst wr_addr", 64'(wr_addr), 64'h0);
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(10);
        check("midrst no frame_err", 64'(err_cnt - e0), 64'h0);
        check("midrst no wr_pulse", 64'(wr_cnt - w0), 64'h0);
        for (int k = 0; k < NUM_REGS; k++) mregs[k] = 8'h00;
        m_wr_addr = 7'h00;
        run_model_frame("post-reset write", 24'h008311, 16);

        // nCS rise together with the final SCLK rise aborts the write
        w0 = wr_cnt; e0 = err_cnt;
        spi_xfer(24'h0080C3, 16, 1'b1, miso, oe);
        check("collide wr_pulse", 64'(wr_cnt - w0), 64'h0);
        check("collide frame_err", 64'(err_cnt - e0), 64'h1);
        check("collide regs", 64'(regs_out), 64'(pack_model()));
        run_model_frame("after collide", 24'h000300, 16);

        // Randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) nb = 16;
            else if (sel < 7) nb = 24;
            else nb = $urandom_range(1, 23);
            full[23] = 1'($urandom_range(0, 1));
            full[22:16] = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
            full[15:8] = 8'($urandom_range(0, 255));
            full[7:0] = 8'($urandom_range(0, 255));
            run_model_frame($sformatf("rand%0d", n), full >> (24 - nb), nb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
